// File: rtl/spi_peripheral_pkg.sv
// spi_pkg: shared types and constants for the SPI peripheral slice.
// Holds the frame FSM encoding, the synchroniser depth and the SPI mode
// helper that decides which SCLK edge samples MOSI.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // chip select inactive
      ST_LOAD  = 2'd1,   // first cycle after chip select falls: load first tx word
      ST_SHIFT = 2'd2    // frame active: sampling and shifting on SCLK edges
   } spi_state_t;

   localparam int SPI_SYNC_STAGES = 2;

   // MOSI is sampled on the rising SCLK edge when CPOL and CPHA agree
   // (modes 0 and 3), otherwise on the falling edge (modes 1 and 2).
   function automatic logic spi_sample_on_rising(input logic cpol, input logic cpha);
      return ~(cpol ^ cpha);
   endfunction

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous pin plus an
// extra history register that yields single-cycle rise/fall pulses.
// RST_VAL is the idle level of the pin, so leaving reset never produces a
// spurious edge.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SPI_SYNC_STAGES-1:0] sync;
   logic                       prev;

   // Shift the pin through the synchroniser and remember the last synced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SPI_SYNC_STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         sync <= {sync[SPI_SYNC_STAGES-2:0], din};
         prev <= sync[SPI_SYNC_STAGES-1];
      end
   end

   assign level = sync[SPI_SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI responder. Oversamples SCLK/CS_n/MOSI in the i_clk
// domain, deserialises WIDTH-bit words (MSB first) and serialises words taken
// from a single-entry valid/ready transmit buffer.
// Transmit buffer handshake: a word is accepted on a cycle where
// i_tx_valid and o_tx_ready are both 1; o_tx_ready drops the next cycle and
// rises again when the word is moved into the shift register.
// Optional macro SPI_PERIPHERAL_MISO_TRISTATE_EN: when defined, o_miso floats
// (Z) whenever the synchronised chip select is inactive or reset is active.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int   WIDTH = 8,
   parameter logic CPOL  = 1'b0,
   parameter logic CPHA  = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sclk,
   input  logic             i_cs_n,
   input  logic             i_mosi,
   output logic             o_miso,
   input  logic [WIDTH-1:0] i_tx_data,
   input  logic             i_tx_valid,
   output logic             o_tx_ready,
   output logic [WIDTH-1:0] o_rx_data,
   output logic             o_rx_valid,
   output logic             o_tx_underrun,
   output logic             o_busy
);

   localparam logic             SAMPLE_RISE = spi_sample_on_rising(CPOL, CPHA);
   localparam int               CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);

   // Synchronised pin views; only SCLK edges matter, its level is not needed.
   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_n_s, cs_n_rise, cs_n_fall;
   logic [SPI_SYNC_STAGES-1:0] mosi_sync;
   logic mosi_s;

   spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_sclk),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_cs_n),
      .level (cs_n_s),
      .rise  (cs_n_rise),
      .fall  (cs_n_fall)
   );

   // MOSI goes through the same number of stages as SCLK so a detected SCLK
   // edge lines up with the MOSI value present at that pin edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) mosi_sync <= '0;
      else          mosi_sync <= {mosi_sync[SPI_SYNC_STAGES-2:0], i_mosi};
   end
   assign mosi_s = mosi_sync[SPI_SYNC_STAGES-1];

   spi_state_t       state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] rx_shift, tx_shift, tx_buf;
   logic             miso_q;
   logic             skip_shift;   // swallow the trailing shift right after a mid-frame reload (CPHA=0)

   logic             sample_edge, shift_edge, do_load;
   logic [WIDTH-1:0] rx_word, next_word;

   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
   assign rx_word     = {rx_shift[WIDTH-2:0], mosi_s};
   // An empty buffer (ready high) sends all zeros.
   assign next_word   = o_tx_ready ? '0 : tx_buf;
   assign do_load     = !cs_n_rise &&
                        ((state == ST_LOAD) ||
                         (state == ST_SHIFT && sample_edge && bit_cnt == LAST_BIT));

   // Frame FSM, bit counter, shift registers and transmit buffer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= ST_IDLE;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         tx_buf        <= '0;
         miso_q        <= 1'b0;
         skip_shift    <= 1'b0;
         o_tx_ready    <= 1'b1;
         o_rx_data     <= '0;
         o_rx_valid    <= 1'b0;
         o_tx_underrun <= 1'b0;
      end else begin
         o_rx_valid    <= 1'b0;
         o_tx_underrun <= 1'b0;

         // Buffer write; a same-cycle load below sees the old content.
         if (i_tx_valid && o_tx_ready) begin
            tx_buf     <= i_tx_data;
            o_tx_ready <= 1'b0;
         end

         if (cs_n_rise) begin
            // End of frame: any partial word is dropped, buffer kept.
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            miso_q     <= 1'b0;
            skip_shift <= 1'b0;
         end else begin
            case (state)
               ST_IDLE:  if (cs_n_fall) state <= ST_LOAD;
               ST_LOAD:  state <= ST_SHIFT;
               ST_SHIFT: begin
                  if (sample_edge) begin
                     rx_shift <= rx_word;
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt    <= '0;
                        o_rx_data  <= rx_word;
                        o_rx_valid <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else if (shift_edge) begin
                     if (skip_shift) begin
                        skip_shift <= 1'b0;
                     end else begin
                        miso_q   <= tx_shift[WIDTH-1];
                        tx_shift <= tx_shift << 1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase

            if (do_load) begin
               if (!o_tx_ready) o_tx_ready    <= 1'b1;
               else             o_tx_underrun <= 1'b1;
               if (CPHA) begin
                  // First bit appears on the first (leading) shift edge.
                  tx_shift <= next_word;
               end else begin
                  // First bit goes out immediately; the trailing edge that
                  // follows a mid-frame reload must not advance past it.
                  miso_q     <= next_word[WIDTH-1];
                  tx_shift   <= next_word << 1;
                  skip_shift <= (state == ST_SHIFT);
               end
            end
         end
      end
   end

   assign o_busy = ~cs_n_s;

`ifdef SPI_PERIPHERAL_MISO_TRISTATE_EN
   assign o_miso = cs_n_s ? 1'bz : miso_q;
`else
   assign o_miso = cs_n_s ? 1'b0 : miso_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench driving four peripherals, one per SPI
// mode (index = CPOL*2 + CPHA), each on its own SCLK/CS_n pair.
module tb_spi_peripheral;

   localparam int HALF = 6;   // SCLK half period in i_clk cycles

`ifdef SPI_PERIPHERAL_MISO_TRISTATE_EN
   localparam logic IDLE_MISO = 1'bz;
`else
   localparam logic IDLE_MISO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sclk, cs_n, tx_valid;
   logic [3:0] miso, tx_ready, rx_valid, underrun, busy;
   logic [7:0] tx_data [4];
   logic [7:0] rx_data [4];
   logic       mosi;

   int total = 0;
   int bad   = 0;
   int rx_cnt [4];
   int ur_cnt [4];
   int act = 0;
   logic       busy_seen;
   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];

   // clock
   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      spi_peripheral #(.WIDTH(8), .CPOL(m >= 2), .CPHA(m % 2 == 1)) dut (
         .i_clk         (clk),
         .i_rst_n       (rst_n),
         .i_sclk        (sclk[m]),
         .i_cs_n        (cs_n[m]),
         .i_mosi        (mosi),
         .o_miso        (miso[m]),
         .i_tx_data     (tx_data[m]),
         .i_tx_valid    (tx_valid[m]),
         .o_tx_ready    (tx_ready[m]),
         .o_rx_data     (rx_data[m]),
         .o_rx_valid    (rx_valid[m]),
         .o_tx_underrun (underrun[m]),
         .o_busy        (busy[m])
      );
   end

   // monitor: count strobes, log received words of the active DUT
   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (rx_valid[d] === 1'b1) begin
            rx_cnt[d]++;
            if (d == act) got_q.push_back(rx_data[d]);
         end
         if (underrun[d] === 1'b1) ur_cnt[d]++;
      end
   end

   // driver: push one word into the transmit buffer of DUT d
   task automatic write_buf(input int d, input logic [7:0] data);
      int n = 0;
      @(negedge clk);
      tx_data[d]  = data;
      tx_valid[d] = 1'b1;
      while (tx_ready[d] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL write_buf dut%0d: tx_ready=%b, required 1 within 100 cycles", d, tx_ready[d]);
      end
      @(negedge clk);
      tx_valid[d] = 1'b0;
   endtask

   // driver: SPI controller frame of nbits bits on DUT d
   task automatic spi_xfer(input int d, input logic [15:0] mo, input int nbits,
                           output logic [15:0] mi);
      logic cpha;
      cpha = (d % 2) == 1;
      mi = '0;
      @(negedge clk);
      cs_n[d] = 1'b0;
      if (!cpha) mosi = mo[nbits-1];
      repeat (8) @(negedge clk);
      busy_seen = busy[d];
      for (int i = nbits - 1; i >= 0; i--) begin
         if (!cpha) begin
            mi = {mi[14:0], miso[d]};
            sclk[d] = ~sclk[d];
            repeat (HALF) @(negedge clk);
            sclk[d] = ~sclk[d];
            if (i > 0) mosi = mo[i-1];
            repeat (HALF) @(negedge clk);
         end else begin
            sclk[d] = ~sclk[d];
            mosi = mo[i];
            repeat (HALF) @(negedge clk);
            mi = {mi[14:0], miso[d]};
            sclk[d] = ~sclk[d];
            repeat (HALF) @(negedge clk);
         end
      end
      cs_n[d] = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         total++; if (tx_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_tx_ready dut%0d: got %b, required 1", d, tx_ready[d]); end
         total++; if (rx_data[d] !== 8'h00) begin bad++; $display("FAIL reset_rx_data dut%0d: got %h, required 00", d, rx_data[d]); end
         total++; if (rx_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_rx_valid dut%0d: got %b, required 0", d, rx_valid[d]); end
         total++; if (underrun[d] !== 1'b0) begin bad++; $display("FAIL reset_underrun dut%0d: got %b, required 0", d, underrun[d]); end
         total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b, required 0", d, busy[d]); end
         total++; if (miso[d] !== IDLE_MISO) begin bad++; $display("FAIL reset_miso dut%0d: got %b, required %b", d, miso[d], IDLE_MISO); end
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_mode0;
      logic [15:0] mi;
      int rx0;
      act = 0;
      rx0 = rx_cnt[0];
      write_buf(0, 8'hA5);
      total++; if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL mode0_ready_after_write: got %b, required 0", tx_ready[0]); end
      spi_xfer(0, 16'h003C, 8, mi);
      total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL mode0_busy: got %b, required 1", busy_seen); end
      total++; if (mi[7:0] !== 8'hA5) begin bad++; $display("FAIL mode0_miso: got %h, required a5", mi[7:0]); end
      total++; if (rx_data[0] !== 8'h3C) begin bad++; $display("FAIL mode0_rx_data: got %h, required 3c", rx_data[0]); end
      total++; if (rx_cnt[0] - rx0 !== 1) begin bad++; $display("FAIL mode0_rx_strobes: got %0d, required 1", rx_cnt[0] - rx0); end
      total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL mode0_ready_after_load: got %b, required 1", tx_ready[0]); end
   endtask

   task automatic test_modes_123;
      logic [15:0] mi;
      int rx0;
      for (int d = 1; d < 4; d++) begin
         act = d;
         rx0 = rx_cnt[d];
         write_buf(d, 8'h81);
         spi_xfer(d, 16'h0081, 8, mi);
         total++; if (mi[7:0] !== 8'h81) begin bad++; $display("FAIL mode%0d_miso: got %h, required 81", d, mi[7:0]); end
         total++; if (rx_data[d] !== 8'h81) begin bad++; $display("FAIL mode%0d_rx_data: got %h, required 81", d, rx_data[d]); end
         total++; if (rx_cnt[d] - rx0 !== 1) begin bad++; $display("FAIL mode%0d_rx_strobes: got %0d, required 1", d, rx_cnt[d] - rx0); end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] mi;
      logic [7:0]  e;
      act = 0;
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h0F);
      write_buf(0, 8'h11);
      fork
         spi_xfer(0, 16'hF00F, 16, mi);
         begin
            repeat (30) @(negedge clk);
            write_buf(0, 8'h22);
         end
      join
      total++; if (mi !== 16'h1122) begin bad++; $display("FAIL b2b_miso: got %h, required 1122", mi); end
      total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_rx_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         total++; if (got_q[0] !== e) begin bad++; $display("FAIL b2b_rx_word: got %h, required %h", got_q[0], e); end
         void'(got_q.pop_front());
      end
   endtask

   task automatic test_underrun;
      logic [15:0] mi;
      int ur0, rx0;
      act = 0;
      ur0 = ur_cnt[0];
      rx0 = rx_cnt[0];
      fork
         spi_xfer(0, 16'h006B, 8, mi);
         begin
            repeat (30) @(negedge clk);
            write_buf(0, 8'hE1);
         end
      join
      total++; if (mi[7:0] !== 8'h00) begin bad++; $display("FAIL underrun_miso: got %h, required 00", mi[7:0]); end
      total++; if (ur_cnt[0] - ur0 !== 1) begin bad++; $display("FAIL underrun_pulses: got %0d, required 1", ur_cnt[0] - ur0); end
      total++; if (rx_data[0] !== 8'h6B) begin bad++; $display("FAIL underrun_rx_data: got %h, required 6b", rx_data[0]); end
      total++; if (rx_cnt[0] - rx0 !== 1) begin bad++; $display("FAIL underrun_rx_strobes: got %0d, required 1", rx_cnt[0] - rx0); end
   endtask

   task automatic test_cs_abort;
      logic [15:0] mi;
      int rx0;
      act = 0;
      rx0 = rx_cnt[0];
      spi_xfer(0, 16'h0015, 5, mi);
      total++; if (rx_cnt[0] - rx0 !== 0) begin bad++; $display("FAIL abort_rx_strobes: got %0d, required 0", rx_cnt[0] - rx0); end
      total++; if (rx_data[0] !== 8'h6B) begin bad++; $display("FAIL abort_rx_held: got %h, required 6b", rx_data[0]); end
      write_buf(0, 8'hC3);
      spi_xfer(0, 16'h0077, 8, mi);
      total++; if (rx_data[0] !== 8'h77) begin bad++; $display("FAIL abort_next_rx: got %h, required 77", rx_data[0]); end
      total++; if (rx_cnt[0] - rx0 !== 1) begin bad++; $display("FAIL abort_next_strobes: got %0d, required 1", rx_cnt[0] - rx0); end
      total++; if (mi[7:0] !== 8'hC3) begin bad++; $display("FAIL abort_next_miso: got %h, required c3", mi[7:0]); end
   endtask

   task automatic test_reset_mid_frame;
      act = 0;
      write_buf(0, 8'h99);
      @(negedge clk);
      cs_n[0] = 1'b0;
      mosi = 1'b1;
      repeat (8) @(negedge clk);
      total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b, required 1", busy[0]); end
      total++; if (miso[0] !== 1'b1) begin bad++; $display("FAIL midrst_first_bit: got %b, required 1", miso[0]); end
      write_buf(0, 8'h55);
      sclk[0] = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk[0] = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk[0] = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL midrst_ready_before: got %b, required 0", tx_ready[0]); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_tx_ready: got %b, required 1", tx_ready[0]); end
      total++; if (rx_data[0] !== 8'h00) begin bad++; $display("FAIL midrst_rx_data: got %h, required 00", rx_data[0]); end
      total++; if (rx_valid[0] !== 1'b0) begin bad++; $display("FAIL midrst_rx_valid: got %b, required 0", rx_valid[0]); end
      total++; if (underrun[0] !== 1'b0) begin bad++; $display("FAIL midrst_underrun: got %b, required 0", underrun[0]); end
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b, required 0", busy[0]); end
      total++; if (miso[0] !== IDLE_MISO) begin bad++; $display("FAIL midrst_miso: got %b, required %b", miso[0], IDLE_MISO); end
      @(negedge clk);
      cs_n[0] = 1'b1;
      sclk[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      sclk     = 4'b1100;
      cs_n     = 4'hF;
      tx_valid = 4'h0;
      mosi     = 1'b0;
      for (int d = 0; d < 4; d++) tx_data[d] = 8'h00;
      test_reset();
      test_mode0();
      test_modes_123();
      test_back_to_back();
      test_underrun();
      test_cs_abort();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
